// File: rtl/cuo_pkg.sv
// Shared state encoding, widths and helpers for the CuO crossbar request scheduler.
package cuo_pkg;

    typedef enum logic [1:0] {
        CUO_IDLE  = 2'd0,
        CUO_ISSUE = 2'd1,
        CUO_WAIT  = 2'd2,
        CUO_RESP  = 2'd3
    } cuo_state_e;

    localparam int CUO_RESULT_W        = 32;
    localparam int CUO_TIMEOUT_DEFAULT = 64;
    localparam int CUO_MAX_REQ         = 8;

    // Input is one-hot, so OR-ing the matching positions yields the index.
    function automatic logic [2:0] cuo_onehot_to_idx(input logic [CUO_MAX_REQ-1:0] oh);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < CUO_MAX_REQ; i++) begin
            idx = idx | (oh[i] ? 3'(i) : 3'd0);
        end
        return idx;
    endfunction

endpackage

// File: rtl/cuo_rr_arbiter.sv
// Combinational round-robin pick: search starts one past the last winner.
module cuo_rr_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req_i,
    input  logic [$clog2(N_REQ)-1:0] ptr_i,
    output logic [N_REQ-1:0]         gnt_oh_o,
    output logic                     any_o
);

    localparam int IDX_W = $clog2(N_REQ);

    logic [N_REQ-1:0] gnt_s;
    logic             found_s;
    logic             hit_s;
    logic [IDX_W-1:0] pos_s;

    // Walk requesters in priority order ptr+1, ptr+2, ... and keep the first hit.
    always_comb begin
        gnt_s   = '0;
        found_s = 1'b0;
        hit_s   = 1'b0;
        pos_s   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            pos_s        = IDX_W'((int'(ptr_i) + k) % N_REQ);
            hit_s        = ~found_s & req_i[pos_s];
            gnt_s[pos_s] = gnt_s[pos_s] | hit_s;
            found_s      = found_s | hit_s;
        end
    end

    assign gnt_oh_o = gnt_s;
    assign any_o    = |req_i;

endmodule

// File: rtl/cuo_request_scheduler.sv
// Shares one CuO crossbar access controller among N_REQ requesters:
// round-robin grant, start pulse, edge-qualified completion with watchdog, response.
module cuo_request_scheduler
    import cuo_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int PRECISION = 12,
    parameter int ROW_W     = 4,
    parameter int TIMEOUT   = CUO_TIMEOUT_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*PRECISION-1:0] req_data,
    input  logic [N_REQ*ROW_W-1:0]    req_row,
    output logic [N_REQ-1:0]          gnt,
    output logic [N_REQ-1:0]          rsp_valid,
    output logic                      rsp_err,
    output logic [CUO_RESULT_W-1:0]   rsp_result,
    output logic                      arr_start,
    output logic [PRECISION-1:0]      arr_data,
    output logic [ROW_W-1:0]          arr_row,
    input  logic                      arr_done,
    input  logic [CUO_RESULT_W-1:0]   arr_result,
    output logic                      busy
);

    localparam int IDX_W = $clog2(N_REQ);

    cuo_state_e              state_q;
    logic [IDX_W-1:0]        ptr_q;
    logic [IDX_W-1:0]        idx_q;
    logic [N_REQ-1:0]        gnt_q;
    logic [N_REQ-1:0]        rsp_valid_q;
    logic                    err_q;
    logic [CUO_RESULT_W-1:0] result_q;
    logic                    arr_start_q;
    logic [PRECISION-1:0]    arr_data_q;
    logic [ROW_W-1:0]        arr_row_q;
    logic                    busy_q;
    logic [7:0]              cnt_q;
    logic                    done_q;

    logic [N_REQ-1:0]        win_oh_s;
    logic                    any_s;
    logic [IDX_W-1:0]        win_idx_s;
    logic [N_REQ-1:0]        idx_oh_s;
    logic                    done_rise_s;

    cuo_rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_arb (
        .req_i    (req),
        .ptr_i    (ptr_q),
        .gnt_oh_o (win_oh_s),
        .any_o    (any_s)
    );

    assign win_idx_s   = IDX_W'(cuo_onehot_to_idx(CUO_MAX_REQ'(win_oh_s)));
    assign idx_oh_s    = {{(N_REQ-1){1'b0}}, 1'b1} << idx_q;
    // A level left high from an earlier access must not count as completion.
    assign done_rise_s = arr_done & ~done_q;

    // Scheduler FSM with registered outputs, data latches and watchdog.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= CUO_IDLE;
            ptr_q       <= IDX_W'(N_REQ - 1);
            idx_q       <= '0;
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            err_q       <= 1'b0;
            result_q    <= '0;
            arr_start_q <= 1'b0;
            arr_data_q  <= '0;
            arr_row_q   <= '0;
            busy_q      <= 1'b0;
            cnt_q       <= 8'd0;
            done_q      <= 1'b0;
        end else begin
            done_q      <= arr_done;
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            arr_start_q <= 1'b0;
            case (state_q)
                CUO_IDLE: begin
                    if (any_s) begin
                        idx_q       <= win_idx_s;
                        ptr_q       <= win_idx_s;
                        arr_data_q  <= req_data[int'(win_idx_s)*PRECISION +: PRECISION];
                        arr_row_q   <= req_row[int'(win_idx_s)*ROW_W +: ROW_W];
                        gnt_q       <= win_oh_s;
                        arr_start_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= CUO_ISSUE;
                    end else begin
                        busy_q      <= 1'b0;
                    end
                end
                CUO_ISSUE: begin
                    cnt_q   <= 8'd0;
                    state_q <= CUO_WAIT;
                end
                CUO_WAIT: begin
                    // The completion edge takes precedence over a simultaneous timeout.
                    if (done_rise_s) begin
                        result_q    <= arr_result;
                        err_q       <= 1'b0;
                        rsp_valid_q <= idx_oh_s;
                        state_q     <= CUO_RESP;
                    end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                        result_q    <= '0;
                        err_q       <= 1'b1;
                        rsp_valid_q <= idx_oh_s;
                        state_q     <= CUO_RESP;
                    end else begin
                        cnt_q       <= cnt_q + 8'd1;
                    end
                end
                CUO_RESP: begin
                    busy_q  <= 1'b0;
                    state_q <= CUO_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= CUO_IDLE;
                end
            endcase
        end
    end

    assign gnt        = gnt_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_err    = err_q;
    assign rsp_result = result_q;
    assign arr_start  = arr_start_q;
    assign arr_data   = arr_data_q;
    assign arr_row    = arr_row_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_cuo_request_scheduler.sv
// Directed self-checking bench for cuo_request_scheduler; the crossbar
// controller is modelled inline by driving arr_done/arr_result.
module tb_cuo_request_scheduler;

    localparam int N_REQ     = 4;
    localparam int PRECISION = 12;
    localparam int ROW_W     = 4;
    localparam int TIMEOUT   = 64;

    logic                       clk;
    logic                       rst_n;
    logic [N_REQ-1:0]           req;
    logic [N_REQ*PRECISION-1:0] req_data;
    logic [N_REQ*ROW_W-1:0]     req_row;
    logic [N_REQ-1:0]           gnt;
    logic [N_REQ-1:0]           rsp_valid;
    logic                       rsp_err;
    logic [31:0]                rsp_result;
    logic                       arr_start;
    logic [PRECISION-1:0]       arr_data;
    logic [ROW_W-1:0]           arr_row;
    logic                       arr_done;
    logic [31:0]                arr_result;
    logic                       busy;

    int n_chk = 0;
    int n_err = 0;

    cuo_request_scheduler #(
        .N_REQ     (N_REQ),
        .PRECISION (PRECISION),
        .ROW_W     (ROW_W),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .req_data   (req_data),
        .req_row    (req_row),
        .gnt        (gnt),
        .rsp_valid  (rsp_valid),
        .rsp_err    (rsp_err),
        .rsp_result (rsp_result),
        .arr_start  (arr_start),
        .arr_data   (arr_data),
        .arr_row    (arr_row),
        .arr_done   (arr_done),
        .arr_result (arr_result),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance n falling edges, flagging any response pulse seen meanwhile.
    task automatic wait_quiet(input int n, output logic spur);
        spur = 1'b0;
        repeat (n) begin
            @(negedge clk);
            if (rsp_valid != 4'b0000) spur = 1'b1;
        end
    endtask

    // Starts at an IDLE falling edge; done edge is placed dly cycles into WAIT.
    task automatic run_txn(input string tag, input logic [3:0] r, input logic [3:0] exp_g,
                           input int dly, input logic [31:0] res, input logic hold);
        logic spur;
        req = r;
        @(negedge clk);
        chk({tag, "_gnt"}, 32'(gnt), 32'(exp_g));
        chk({tag, "_start"}, 32'(arr_start), 32'd1);
        if (!hold) req = 4'b0000;
        wait_quiet(dly, spur);
        chk({tag, "_early_rsp"}, 32'(spur), 32'd0);
        arr_done   = 1'b1;
        arr_result = res;
        @(negedge clk);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(exp_g));
        chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
        chk({tag, "_rsp_result"}, rsp_result, res);
        @(negedge clk);
        arr_done = 1'b0;
        chk({tag, "_rsp_drop"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL time_limit: bench did not reach its end, got timeout expected completion");
        $fatal(1, "time limit expired");
    end

    initial begin
        logic spur;
        logic spur2;
        logic found;
        int   k;

        rst_n      = 1'b0;
        req        = 4'b0000;
        arr_done   = 1'b0;
        arr_result = 32'd0;
        req_data   = {12'h444, 12'hABC, 12'h222, 12'h111};
        req_row    = {4'd4, 4'd3, 4'd2, 4'd1};

        repeat (2) @(negedge clk);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_arr_start", 32'(arr_start), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Fairness: from reset the pointer sits at 3, so order is 0,1,2,3,0.
        run_txn("rr0", 4'b1111, 4'b0001, 2, 32'h0000_1000, 1'b1);
        run_txn("rr1", 4'b1111, 4'b0010, 2, 32'h0000_1001, 1'b1);
        run_txn("rr2", 4'b1111, 4'b0100, 2, 32'h0000_1002, 1'b1);
        run_txn("rr3", 4'b1111, 4'b1000, 2, 32'h0000_1003, 1'b1);
        run_txn("rr4", 4'b1111, 4'b0001, 1, 32'h0000_1004, 1'b1);
        req = 4'b0000;

        // Single request with data/row latching, done 25 cycles after start.
        req = 4'b0100;
        @(negedge clk);
        chk("single_gnt", 32'(gnt), 32'h4);
        chk("single_data", 32'(arr_data), 32'hABC);
        chk("single_row", 32'(arr_row), 32'd3);
        chk("single_busy", 32'(busy), 32'd1);
        req = 4'b0000;
        wait_quiet(25, spur);
        chk("single_early_rsp", 32'(spur), 32'd0);
        chk("single_data_hold", 32'(arr_data), 32'hABC);
        arr_done   = 1'b1;
        arr_result = 32'h0000_0123;
        @(negedge clk);
        chk("single_rsp_valid", 32'(rsp_valid), 32'h4);
        chk("single_rsp_result", rsp_result, 32'h0000_0123);
        chk("single_rsp_err", 32'(rsp_err), 32'd0);
        @(negedge clk);
        arr_done = 1'b0;
        chk("single_rsp_drop", 32'(rsp_valid), 32'd0);
        chk("single_result_hold", rsp_result, 32'h0000_0123);

        // Stale done: level already high at start must not complete the access.
        req      = 4'b0001;
        arr_done = 1'b1;
        @(negedge clk);
        chk("stale_gnt", 32'(gnt), 32'h1);
        req = 4'b0000;
        wait_quiet(3, spur);
        arr_done = 1'b0;
        wait_quiet(10, spur2);
        chk("stale_no_rsp", 32'(spur | spur2), 32'd0);
        chk("stale_busy", 32'(busy), 32'd1);
        arr_done   = 1'b1;
        arr_result = 32'h0000_0456;
        @(negedge clk);
        chk("stale_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("stale_rsp_result", rsp_result, 32'h0000_0456);
        @(negedge clk);
        arr_done = 1'b0;

        // Timeout: request sampled in cycle 0, arr_start in cycle 1, TIMEOUT WAIT
        // cycles, response in cycle TIMEOUT+2.
        req = 4'b1000;
        @(negedge clk);
        chk("to_gnt", 32'(gnt), 32'h8);
        chk("to_start", 32'(arr_start), 32'd1);
        req   = 4'b0000;
        found = 1'b0;
        k     = 0;
        while (!found && k < 200) begin
            @(negedge clk);
            k++;
            if (rsp_valid != 4'b0000) found = 1'b1;
        end
        chk("to_seen", 32'(found), 32'd1);
        chk("to_cycle", 32'(1 + k), 32'(TIMEOUT + 2));
        chk("to_rsp_valid", 32'(rsp_valid), 32'h8);
        chk("to_rsp_err", 32'(rsp_err), 32'd1);
        chk("to_rsp_result", rsp_result, 32'd0);
        @(negedge clk);
        chk("to_busy_after", 32'(busy), 32'd0);

        // Edge on the last WAIT cycle collides with the timeout; the edge wins.
        run_txn("collide", 4'b0010, 4'b0010, TIMEOUT, 32'hCAFE_0001, 1'b0);

        // Reset mid-WAIT clears everything at once and reloads the pointer.
        req = 4'b0100;
        @(negedge clk);
        chk("mid_gnt", 32'(gnt), 32'h4);
        req = 4'b0000;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_gnt", 32'(gnt), 32'd0);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("mid_rst_rsp_result", rsp_result, 32'd0);
        chk("mid_rst_arr_start", 32'(arr_start), 32'd0);
        chk("mid_rst_arr_data", 32'(arr_data), 32'd0);
        chk("mid_rst_arr_row", 32'(arr_row), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        req   = 4'b1001;
        @(negedge clk);
        chk("post_rst_gnt", 32'(gnt), 32'h1);
        chk("post_rst_data", 32'(arr_data), 32'h111);
        chk("post_rst_row", 32'(arr_row), 32'd1);
        wait_quiet(2, spur);
        chk("post_rst_early_rsp", 32'(spur), 32'd0);
        arr_done   = 1'b1;
        arr_result = 32'h0000_0789;
        @(negedge clk);
        chk("post_rst_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("post_rst_rsp_result", rsp_result, 32'h0000_0789);
        @(negedge clk);
        arr_done = 1'b0;
        // Requester 3 is still asking and is next after 0.
        run_txn("post_rst_next", 4'b1001, 4'b1000, 3, 32'h0000_0abc, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
